tft_client_arbiter: RTL and testbench
=====================================

# tft_client_arbiter

Parametrised arbiter for the shared TFT SPI transmitter. It replaces the hard-wired init/scene/player enable chain and priority mux with N requesting clients. Each grant follows an explicit enable/busy handshake. Selection is fixed-priority or round-robin, and an optional watchdog reclaims the bus from a hung client. It sits between the drawing clients and `tft_spi`.

## Interface
Parameters:
- `N_CLIENTS`, default 4: number of clients, 2..16.
- `DATA_W`, default 8: width of the SPI data byte.
- `ROUND_ROBIN`, default 0: 0 selects fixed priority (lowest index wins); 1 selects round-robin.
- `WDOG_CYCLES`, default 2**20: watchdog limit in clk cycles. Used only when the watchdog is compiled in.

Ports:
- `clk`  in  1  the single clock. All logic is on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req`  in  N_CLIENTS  level request per client. Held until the client is granted.
- `client_busy`  in  N_CLIENTS  per-client busy, as output by each client.
- `client_data`  in  N_CLIENTS*DATA_W  client i drives bits [i*DATA_W +: DATA_W].
- `client_dc`  in  N_CLIENTS  per-client D/C bit.
- `client_transmit`  in  N_CLIENTS  per-client transmit strobe.
- `spi_busy`  in  1  busy from `tft_spi`.
- `enable`  out  N_CLIENTS  one-hot grant, registered.
- `spi_data`  out  DATA_W  data of the granted client; 0 when no client is granted.
- `spi_dc`  out  1  D/C of the granted client; 0 when no client is granted.
- `spi_transmit`  out  1  transmit of the granted client; 0 when no client is granted.
- `grant_id`  out  $clog2(N_CLIENTS)  index of the current or last granted client.
- `idle`  out  1  high when in IDLE.
- `timeout`  out  1  one-cycle pulse when the watchdog fires.

## Operation
States are IDLE, GRANT, ACTIVE and DRAIN.

- **IDLE**
  - If any `req` is high, pick winner g, register `enable[g]=1` and `grant_id=g`, and go to GRANT.
  - Fixed priority: the lowest set index wins.
  - Round-robin: search starts at last_grant+1 modulo N_CLIENTS.
- **GRANT**
  - Enable is held. Wait for `client_busy[g]=1`, then go to ACTIVE.
  - A client that is not busy in the first enabled cycle is never treated as finished.
- **ACTIVE**
  - Enable is held. When `client_busy[g]=0`, clear `enable` and go to DRAIN.
- **DRAIN**
  - `enable` is all zero and the mux outputs are 0.
  - Wait until `spi_busy=0`, then go to IDLE.
  - This guarantees the last byte leaves the transmitter before the next client is granted.

Other rules:
- The mux is combinational from the registered one-hot `enable`. Its select is never computed from `req`.
- `req` deasserting during GRANT or ACTIVE is ignored; the grant runs to completion.
- If requests occur back-to-back, IDLE lasts at least 1 cycle between grants.
- The round-robin pointer is updated only on entry to GRANT.

## Timing
- **Reset values:** state IDLE, `enable`=0, `grant_id`=0, `idle`=1, `timeout`=0, round-robin pointer N_CLIENTS-1 (so client 0 is first).
- **Latency:** a `req` sampled in IDLE at edge k gives `enable` high after edge k.
- **Release:** `client_busy[g]` low sampled at edge k gives `enable` low after edge k. `idle` rises the cycle after `spi_busy` is sampled low in DRAIN.
- **Reset mid-operation:** `rst` high at any edge forces all reset values after that edge. `spi_transmit` is therefore 0 after that edge.
- **Simultaneous events:** a request arriving in DRAIN waits for IDLE. A `client_busy` fall in the same cycle as a watchdog expiry is treated as normal completion, and `timeout` does not pulse.

## Configuration
Macro `TFT_ARB_WATCHDOG_EN`:
- **Defined:**
  - A counter of width $clog2(WDOG_CYCLES+1) clears on entry to GRANT and increments in GRANT and ACTIVE.
  - When it reaches WDOG_CYCLES, `enable` drops, `timeout` pulses for 1 cycle and the state goes to DRAIN.
  - `grant_id` keeps the offending index.
- **Not defined:** there is no counter, `timeout` is tied 0, and a hung client holds the bus forever.

## Structure
- **Package `tft_arb_pkg`:** state encoding (IDLE=0, GRANT=1, ACTIVE=2, DRAIN=3) and the `TFT_ARB_MAX_CLIENTS`=16 limit constant.
- **Sub-module `rr_priority_picker`:** combinational. Inputs are the request vector and the start index; outputs are the winner index and a valid bit. Fixed priority uses start index 0.

## Test plan
- **Reset:** hold `rst` 3 cycles with `req`=4'b1111 → `enable`=0, `idle`=1. One cycle after release, `enable`=4'b0001.
- **Fixed priority:** `req`=4'b1010; client 1 busy for 5 cycles; `spi_busy` low 2 cycles after → `enable`=4'b0010 for the GRANT+5-cycle busy window. Then DRAIN for 2 cycles, then IDLE for 1 cycle, then `enable`=4'b1000.
- **Round-robin:** `ROUND_ROBIN`=1, all `req` held high → grant order 0,1,2,3,0. `grant_id` follows the same order.
- **Mux isolation:** `client_transmit`=4'b1111 with distinct data 0xA0..0xA3 → `spi_data` equals only the granted client's byte. `spi_transmit`=0 in IDLE and DRAIN.
- **Watchdog:** macro defined, `WDOG_CYCLES`=16, client 2 busy forever → `enable[2]` drops after 16 cycles in GRANT+ACTIVE, `timeout` pulses once, `grant_id`=2, and the next request is then served.
- **Reset mid-grant:** assert `rst` during ACTIVE → `enable`=0 and `spi_transmit`=0 on the next cycle. After release, client 0 is granted first.

Source files
------------

// File: rtl/tft_arb_pkg.sv
// Shared definitions for the TFT SPI client arbiter: FSM state encoding and
// the client-count limit.
package tft_arb_pkg;

    localparam int TFT_ARB_MAX_CLIENTS = 16;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_GRANT  = 2'd1,
        ST_ACTIVE = 2'd2,
        ST_DRAIN  = 2'd3
    } arb_state_t;

endpackage

// File: rtl/rr_priority_picker.sv
// Combinational rotating-priority picker: first set request at or after
// 'start' (wrapping), so start = 0 gives plain lowest-index priority.
module rr_priority_picker #(
    parameter int N_CLIENTS = 4,
    parameter int IDW       = $clog2(N_CLIENTS)
) (
    input  logic [N_CLIENTS-1:0] req,
    input  logic [IDW-1:0]       start,
    output logic [IDW-1:0]       winner,
    output logic                 valid
);

    logic [IDW:0] idx;

    always_comb begin
        valid  = 1'b0;
        winner = '0;
        idx    = '0;
        for (int i = 0; i < N_CLIENTS; i++) begin
            idx = {1'b0, start} + (IDW+1)'(i);
            if (idx >= (IDW+1)'(N_CLIENTS)) idx = idx - (IDW+1)'(N_CLIENTS);
            if (!valid && req[idx[IDW-1:0]]) begin
                valid  = 1'b1;
                winner = idx[IDW-1:0];
            end
        end
    end

endmodule

// File: rtl/tft_client_arbiter.sv
// N-client arbiter in front of tft_spi: enable/busy handshake per grant, drain
// of the transmitter between grants. Optional watchdog via TFT_ARB_WATCHDOG_EN.
module tft_client_arbiter
    import tft_arb_pkg::*;
#(
    parameter int N_CLIENTS   = 4,
    parameter int DATA_W      = 8,
    parameter int ROUND_ROBIN = 0,
    parameter int WDOG_CYCLES = 2**20
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [N_CLIENTS-1:0]          req,
    input  logic [N_CLIENTS-1:0]          client_busy,
    input  logic [N_CLIENTS*DATA_W-1:0]   client_data,
    input  logic [N_CLIENTS-1:0]          client_dc,
    input  logic [N_CLIENTS-1:0]          client_transmit,
    input  logic                          spi_busy,
    output logic [N_CLIENTS-1:0]          enable,
    output logic [DATA_W-1:0]             spi_data,
    output logic                          spi_dc,
    output logic                          spi_transmit,
    output logic [$clog2(N_CLIENTS)-1:0]  grant_id,
    output logic                          idle,
    output logic                          timeout
);

    localparam int IDW = $clog2(N_CLIENTS);
    localparam logic [IDW-1:0] LAST_ID = IDW'(N_CLIENTS - 1);

    if (N_CLIENTS < 2 || N_CLIENTS > TFT_ARB_MAX_CLIENTS) begin : g_bad_n
        $error("tft_client_arbiter: N_CLIENTS must be 2..16");
    end

    arb_state_t           state, state_n;
    logic [N_CLIENTS-1:0] enable_n;
    logic [IDW-1:0]       grant_n, rr_ptr, ptr_n, start, pick_id;
    logic                 pick_vld, timeout_n, wd_expire, cur_busy;

    assign start    = (ROUND_ROBIN != 0) ? ((rr_ptr == LAST_ID) ? '0 : rr_ptr + IDW'(1)) : '0;
    assign cur_busy = client_busy[grant_id];
    assign idle     = (state == ST_IDLE);

    rr_priority_picker #(
        .N_CLIENTS (N_CLIENTS),
        .IDW       (IDW)
    ) u_picker (
        .req    (req),
        .start  (start),
        .winner (pick_id),
        .valid  (pick_vld)
    );

`ifdef TFT_ARB_WATCHDOG_EN
    localparam int WDW = $clog2(WDOG_CYCLES + 1);
    logic [WDW-1:0] wd_cnt;

    // Held at zero while idle, so it starts from zero on entry to GRANT.
    always_ff @(posedge clk) begin
        if (rst || state == ST_IDLE)
            wd_cnt <= '0;
        else if (state == ST_GRANT || state == ST_ACTIVE)
            wd_cnt <= wd_cnt + WDW'(1);
    end

    assign wd_expire = (state == ST_GRANT || state == ST_ACTIVE) &&
                       (wd_cnt == WDW'(WDOG_CYCLES - 1));
`else
    assign wd_expire = 1'b0;

    if (WDOG_CYCLES < 1) begin : g_bad_wdog
        $error("tft_client_arbiter: WDOG_CYCLES must be positive");
    end
`endif

    always_comb begin
        state_n   = state;
        enable_n  = enable;
        grant_n   = grant_id;
        ptr_n     = rr_ptr;
        timeout_n = 1'b0;
        case (state)
            ST_IDLE: begin
                if (pick_vld) begin
                    state_n           = ST_GRANT;
                    enable_n          = '0;
                    enable_n[pick_id] = 1'b1;
                    grant_n           = pick_id;
                    ptr_n             = pick_id;
                end
            end
            ST_GRANT: begin
                if (wd_expire) begin
                    state_n   = ST_DRAIN;
                    enable_n  = '0;
                    timeout_n = 1'b1;
                end else if (cur_busy) begin
                    state_n = ST_ACTIVE;
                end
            end
            ST_ACTIVE: begin
                // A busy fall wins over a coincident watchdog expiry.
                if (!cur_busy) begin
                    state_n  = ST_DRAIN;
                    enable_n = '0;
                end else if (wd_expire) begin
                    state_n   = ST_DRAIN;
                    enable_n  = '0;
                    timeout_n = 1'b1;
                end
            end
            ST_DRAIN: begin
                if (!spi_busy) state_n = ST_IDLE;
            end
            default: state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            enable   <= '0;
            grant_id <= '0;
            rr_ptr   <= LAST_ID;
            timeout  <= 1'b0;
        end else begin
            state    <= state_n;
            enable   <= enable_n;
            grant_id <= grant_n;
            rr_ptr   <= ptr_n;
            timeout  <= timeout_n;
        end
    end

    // Output mux selected only by the registered one-hot enable.
    always_comb begin
        spi_data     = '0;
        spi_dc       = 1'b0;
        spi_transmit = 1'b0;
        for (int i = 0; i < N_CLIENTS; i++) begin
            if (enable[i]) begin
                spi_data     = spi_data | client_data[i*DATA_W +: DATA_W];
                spi_dc       = spi_dc | client_dc[i];
                spi_transmit = spi_transmit | client_transmit[i];
            end
        end
    end

endmodule

// File: tb/tb_tft_client_arbiter.sv
// Random-stimulus scoreboard bench for tft_client_arbiter: a fixed-priority
// and a round-robin instance, each with its own client models and reference.
module tb_tft_client_arbiter;

    localparam int N     = 4;
    localparam int DW    = 8;
    localparam int WD    = 16;
    localparam int ND    = 2;
    localparam int TOTAL = 3000;
`ifdef TFT_ARB_WATCHDOG_EN
    localparam bit WD_ON = 1'b1;
`else
    localparam bit WD_ON = 1'b0;
`endif

    typedef struct packed {
        logic [N-1:0]  en;
        logic          idle;
        logic [1:0]    gid;
        logic [DW-1:0] data;
        logic          dc;
        logic          tx;
        logic          tmo;
    } obs_t;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req_v  [ND];
    logic [N-1:0]    busy_v [ND];
    logic [N*DW-1:0] data;
    logic [N-1:0]    dc, tx;
    logic            spi_busy;

    logic [N-1:0]  en0, en1;
    logic [DW-1:0] sd0, sd1;
    logic          sdc0, sdc1, stx0, stx1, idle0, idle1, tmo0, tmo1;
    logic [1:0]    gid0, gid1;
    obs_t          act0, act1;

    assign act0 = {en0, idle0, gid0, sd0, sdc0, stx0, tmo0};
    assign act1 = {en1, idle1, gid1, sd1, sdc1, stx1, tmo1};

    always #5 clk = ~clk;

    tft_client_arbiter #(.N_CLIENTS(N), .DATA_W(DW), .ROUND_ROBIN(0), .WDOG_CYCLES(WD)) u_fp (
        .clk(clk), .rst(rst), .req(req_v[0]), .client_busy(busy_v[0]), .client_data(data),
        .client_dc(dc), .client_transmit(tx), .spi_busy(spi_busy), .enable(en0),
        .spi_data(sd0), .spi_dc(sdc0), .spi_transmit(stx0), .grant_id(gid0),
        .idle(idle0), .timeout(tmo0));

    tft_client_arbiter #(.N_CLIENTS(N), .DATA_W(DW), .ROUND_ROBIN(1), .WDOG_CYCLES(WD)) u_rr (
        .clk(clk), .rst(rst), .req(req_v[1]), .client_busy(busy_v[1]), .client_data(data),
        .client_dc(dc), .client_transmit(tx), .spi_busy(spi_busy), .enable(en1),
        .spi_data(sd1), .spi_dc(sdc1), .spi_transmit(stx1), .grant_id(gid1),
        .idle(idle1), .timeout(tmo1));

    int   n_checks = 0;
    int   n_fail   = 0;
    obs_t exp_q0[$], exp_q1[$];

    // Reference model: who owns the bus, whether the owner has shown busy,
    // whether the transmitter is being drained, last winner, watchdog age.
    int m_owner [ND], m_last [ND], m_gid [ND], m_wd [ND];
    bit m_started [ND], m_drain [ND], m_tmo [ND];

    // Client models: 0 quiet, 1 requesting, 2 granted/pre-busy, 3 busy.
    int       cst  [ND][N];
    int       ccnt [ND][N];
    logic [N-1:0] en_prev [ND];
    int       mode;

    function automatic int pick(int d, logic [N-1:0] r);
        for (int k = 0; k < N; k++) begin
            int c;
            c = (d == 1) ? (m_last[d] + 1 + k) % N : k;
            if (r[c]) return c;
        end
        return -1;
    endfunction

    task automatic model_step(int d);
        if (rst) begin
            m_owner[d] = -1; m_drain[d] = 0; m_started[d] = 0;
            m_last[d] = N - 1; m_gid[d] = 0; m_tmo[d] = 0; m_wd[d] = 0;
        end else begin
            m_tmo[d] = 0;
            if (m_drain[d]) begin
                if (!spi_busy) m_drain[d] = 0;
            end else if (m_owner[d] >= 0) begin
                m_wd[d]++;
                if (m_started[d] && !busy_v[d][m_owner[d]]) begin
                    m_owner[d] = -1; m_drain[d] = 1;
                end else if (WD_ON && m_wd[d] == WD) begin
                    m_owner[d] = -1; m_drain[d] = 1; m_tmo[d] = 1;
                end else if (busy_v[d][m_owner[d]]) begin
                    m_started[d] = 1;
                end
            end else if (req_v[d] != '0) begin
                int w;
                w = pick(d, req_v[d]);
                m_owner[d] = w; m_gid[d] = w; m_last[d] = w;
                m_started[d] = 0; m_wd[d] = 0;
            end
        end
    endtask

    function automatic obs_t expect_now(int d);
        obs_t e;
        int   o;
        o = m_owner[d];
        e = '0;
        e.idle = (o < 0) && !m_drain[d];
        e.gid  = 2'(m_gid[d]);
        e.tmo  = m_tmo[d];
        if (o >= 0) begin
            e.en[o] = 1'b1;
            e.data  = data[o*DW +: DW];
            e.dc    = dc[o];
            e.tx    = tx[o];
        end
        return e;
    endfunction

    task automatic chk(string name, int d, int act, int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s dut%0d t=%0t got=%0h want=%0h", name, d, $time, act, exp);
        end
    endtask

    task automatic update_clients(int d, logic [N-1:0] en);
        for (int i = 0; i < N; i++) begin
            bit allow, rise, hang;
            allow = (mode != 2) || (i >= 2);
            rise  = en[i] && !en_prev[d][i];
            hang  = (mode == 2) && (i == 2);
            case (cst[d][i])
                0: begin
                    if (ccnt[d][i] > 0) ccnt[d][i]--;
                    else if (allow && (mode == 1 || $urandom_range(2) == 0)) cst[d][i] = 1;
                end
                1: if (rise) begin cst[d][i] = 2; ccnt[d][i] = $urandom_range(0, 2); end
                2: begin
                    if (!en[i]) cst[d][i] = rst ? 1 : 0;
                    else if (ccnt[d][i] == 0) begin cst[d][i] = 3; ccnt[d][i] = $urandom_range(1, 6); end
                    else ccnt[d][i]--;
                end
                default: begin
                    if (!en[i]) begin
                        cst[d][i] = rst ? 1 : 0; ccnt[d][i] = $urandom_range(0, 4);
                    end else if (!hang) begin
                        if (ccnt[d][i] <= 1) begin
                            cst[d][i] = (mode == 1) ? 1 : 0; ccnt[d][i] = $urandom_range(0, 4);
                        end else ccnt[d][i]--;
                    end
                end
            endcase
            busy_v[d][i] = (cst[d][i] == 3) || (cst[d][i] < 2 && $urandom_range(3) == 0);
            req_v[d][i]  = (cst[d][i] == 1) || (cst[d][i] >= 2 && $urandom_range(1) == 1);
        end
        en_prev[d] = en;
    endtask

    initial begin
        rst = 1'b1; spi_busy = 1'b0; data = '0; dc = '0; tx = '0; mode = 1;
        for (int d = 0; d < ND; d++) begin
            req_v[d] = '1; busy_v[d] = '0; en_prev[d] = '0;
            for (int i = 0; i < N; i++) begin cst[d][i] = 1; ccnt[d][i] = 0; end
        end
        for (int cyc = 0; cyc < TOTAL; cyc++) begin
            @(posedge clk);
            for (int d = 0; d < ND; d++) model_step(d);
            #1;
            if (cyc < 400) mode = 1;
            else if (WD_ON && cyc >= 2200 && cyc < 2600) mode = 2;
            else mode = 0;
            update_clients(0, en0);
            update_clients(1, en1);
            // Three reset edges at start, then occasional resets mid-grant.
            rst = (cyc < 2) ||
                  (mode != 2 && m_owner[0] >= 0 && m_started[0] && $urandom_range(39) == 0);
            data     = {$urandom};
            dc       = 4'($urandom);
            tx       = 4'($urandom);
            spi_busy = ($urandom_range(1) == 1);
            exp_q0.push_back(expect_now(0));
            exp_q1.push_back(expect_now(1));
        end
        @(negedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Monitor: compare every presented output against the queued expectation.
    initial begin
        forever begin
            @(negedge clk);
            for (int d = 0; d < ND; d++) begin
                obs_t e, a;
                bit   have;
                have = (d == 0) ? (exp_q0.size() > 0) : (exp_q1.size() > 0);
                if (have) begin
                    e = (d == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
                    a = (d == 0) ? act0 : act1;
                    chk("enable",       d, int'(a.en),   int'(e.en));
                    chk("idle",         d, int'(a.idle), int'(e.idle));
                    chk("grant_id",     d, int'(a.gid),  int'(e.gid));
                    chk("spi_data",     d, int'(a.data), int'(e.data));
                    chk("spi_dc",       d, int'(a.dc),   int'(e.dc));
                    chk("spi_transmit", d, int'(a.tx),   int'(e.tx));
                    chk("timeout",      d, int'(a.tmo),  int'(e.tmo));
                end
            end
        end
    end

endmodule
